// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with a valid/ready handshake, an optional
// two-entry skid buffer that gives a registered in_ready, flush, and a back-pressure counter.
module pipe_stage_elastic #(
    parameter int unsigned      WIDTH          = 32,
    parameter bit               SKID           = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned      CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bp_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0] bp_cycles_q, bp_cycles_d;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    // Valid bits are decoded from the state; TWO is unreachable when SKID=0.
    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_TWO);

    always_comb begin
        if (SKID) begin
            in_ready = !skid_valid;
        end else begin
            in_ready = !main_valid || out_ready;
        end
    end

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    assign bp_cycles = bp_cycles_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = in_data;
                end
            end
            ST_ONE: begin
                // Without a skid slot, an input fire implies the output fires too.
                if (in_fire && (out_fire || !SKID)) begin
                    main_data_d = in_data;
                end else if (in_fire) begin
                    state_d     = ST_TWO;
                    skid_data_d = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_data_d = RESET_VAL;
                skid_data_d = RESET_VAL;
            end else begin
                main_data_d = main_data_q;
                skid_data_d = skid_data_q;
            end
        end
    end

    always_comb begin
        bp_cycles_d = bp_cycles_q;
        if (main_valid && !out_ready && (bp_cycles_q != '1)) begin
            bp_cycles_d = bp_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= RESET_VAL;
            skid_data_q <= RESET_VAL;
            bp_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            bp_cycles_q <= bp_cycles_d;
        end
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Generic, parametrised pipeline stage register with valid/ready handshake, replacing the fixed-field stall/clear registers between CPU stages. It carries an arbitrary-width payload: packed instruction, PC, operands and write address. It tracks a per-stage valid bit so bubbles are explicit rather than encoded as all-zero instructions, and it supports flush. In skid mode it holds up to two entries so that `in_ready` is fully registered, which breaks the combinational stall path from later stages back to IF.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `RESET_VAL`, 0: payload value held by empty entries after reset or flush (`WIDTH` bits).
- `CLEAR_ON_FLUSH`, 1: 1 = flush writes `RESET_VAL` into the data registers; 0 = data registers keep their contents and only the valid bits clear.
- `CNT_W`, 16: width of the back-pressure counter.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: discards all held entries, including any input accepted in the same cycle.
- `in_valid`, in, 1: upstream offers `in_data`.
- `in_ready`, out, 1: stage can accept an entry this cycle.
- `in_data`, in, `WIDTH`: incoming payload.
- `out_valid`, out, 1: `out_data` holds a real entry.
- `out_ready`, in, 1: downstream accepts the entry this cycle.
- `out_data`, out, `WIDTH`: oldest held payload.
- `occupancy`, out, 2: number of held entries, 0..2.
- `bp_cycles`, out, `CNT_W`: saturating count of cycles with `out_valid & !out_ready`.

## Operation
- Transfers:
  - Input fire is `in_valid & in_ready`.
  - Output fire is `out_valid & out_ready`.
- State is two registers:
  - main: `main_valid`, `main_data`.
  - skid: `skid_valid`, `skid_data`. Present only when `SKID=1`.
- Outputs:
  - `out_valid = main_valid`.
  - `out_data = main_data`.
  - `occupancy = main_valid + skid_valid`.
- SKID=1 states:
  - EMPTY: nothing held.
  - ONE: main held.
  - TWO: main and skid held.
  - `in_ready = !skid_valid`, a function of registers only.
- SKID=1 transitions:
  - EMPTY, input fire: → ONE, `main <= in_data`.
  - ONE, input and output fire together: stays ONE, `main <= in_data`.
  - ONE, input fire only: → TWO, `skid <= in_data`.
  - ONE, output fire only: → EMPTY.
  - TWO, output fire: → ONE, `main <= skid_data`, `skid_valid <= 0`. No input fire is possible in TWO.
  - No fire: state and data unchanged.
- SKID=0:
  - `in_ready = !main_valid | out_ready` (combinational).
  - On input fire `main <= in_data`.
  - On output fire without input fire, `main_valid <= 0`.
- Priority, highest first: `reset` > `flush` > handshake updates.
- Flush:
  - Next state is EMPTY and an input accepted in the flush cycle is dropped.
  - If `CLEAR_ON_FLUSH=1`, both data registers load `RESET_VAL`.
  - `bp_cycles` is not affected by flush.
- Reset:
  - Both valid bits are cleared.
  - Both data registers load `RESET_VAL`.
  - `bp_cycles` is cleared to 0.
- `bp_cycles`:
  - Increments by 1 in every non-reset cycle with `out_valid & !out_ready`, including flush cycles.
  - Holds at `2^CNT_W-1`; it does not wrap.
- Payload is never modified. Output order equals input acceptance order with no loss or duplication, except for entries discarded by flush.

## Timing
- Latency: an input fire at edge N gives `out_valid=1` with that data after edge N; no combinational in-to-out path.
- Throughput: one transfer per cycle sustained in both modes when `out_ready=1`.
- SKID=1 `in_ready` deasserts the cycle after the second entry is captured. It reasserts the cycle after any output fire from TWO.
- Values after a reset edge:
  - `out_valid` = 0, `out_data` = `RESET_VAL`, `occupancy` = 0, `bp_cycles` = 0.
  - `in_ready` = 1.
  - In SKID=0 this follows from `main_valid=0`.
- Reset asserted mid-operation (any state) discards all entries at that edge, with the same result as flush plus the counter clear.
- Flush together with `out_ready=1`: the downstream consumes the current `out_data` in that cycle; the stage is EMPTY afterwards.
- Changes to `in_data` while `in_valid=1` and `in_ready=0` are permitted. The value captured is the one present at the fire edge.

## Test plan
- Reset, then stream 0x1..0x8 with `out_ready=1` (both modes) -> outputs 0x1..0x8 one per cycle, each 1 cycle after acceptance; `occupancy`≤1; `bp_cycles`=0.
- SKID=1: accept 0xA then 0xB with `out_ready=0` -> `occupancy`=2, `in_ready`=0 from the next cycle. Raise `out_ready` -> 0xA then 0xB on consecutive cycles, and `in_ready`=1 one cycle after the first pop.
- SKID=0: hold `out_ready=0` with 0xC held -> `in_ready`=0 in the same cycle. Raise `out_ready` together with `in_valid` carrying 0xD -> 0xC popped and 0xD captured at the same edge.
- TWO state holding 0x11/0x22, then assert `flush` with `in_valid`=1 and `in_data`=0x33 -> next cycle `out_valid`=0, `occupancy`=0, 0x33 never appears. With `CLEAR_ON_FLUSH`=1, `out_data`=`RESET_VAL`.
- `CNT_W`=3, `out_valid`=1, `out_ready`=0 for 10 cycles -> `bp_cycles` reads 7 and stays 7. Reset -> 0.
- `reset` asserted in state TWO with `in_valid`=1 -> after the edge, `out_valid`=0, `in_ready`=1, `out_data`=`RESET_VAL`, and the first post-reset input appears normally.
